msrv32_dbus_arbiter: RTL and testbench
======================================

// Module: msrv32_dbus_arbiter
// PURPOSE
//  Shares the single AHB-Lite data port between the load unit (reads) and msrv32_store_unit (writes).
//  Arbitrates, sequences the AHB address and data phases one transfer at a time, and returns completion or error.
//  Raises a pipeline stall while a request is outstanding.
//  Sits between the load/store units and the core's external data bus.
// PARAMETERS
//  TIMEOUT  16  cycles ahb_hready_in may stay low in ADDR/DATA before the transfer is abandoned (>=2)
// PORTS
//  clk_in          in   1   core clock, rising edge
//  rst_n_in        in   1   asynchronous, active-low reset
//  ld_req_in       in   1   load request, held until ld_valid_out
//  ld_addr_in      in   32  load byte address
//  ld_size_in      in   2   00 byte, 01 half, 10 word
//  ld_gnt_out      out  1   pulse: load address phase accepted
//  ld_valid_out    out  1   pulse: ld_rdata_out valid
//  ld_rdata_out    out  32  captured ahb_hrdata_in (0 on error)
//  st_req_in       in   1   store request (store unit wr_req_out), held until st_done_out
//  st_addr_in      in   32  store address (store unit d_addr_out)
//  st_wdata_in     in   32  lane-aligned write data
//  st_mask_in      in   4   byte-lane write mask
//  st_gnt_out      out  1   pulse: store address phase accepted
//  st_done_out     out  1   pulse: store completed
//  ahb_haddr_out   out  32  AHB address
//  ahb_htrans_out  out  2   00 IDLE, 10 NONSEQ only
//  ahb_hwrite_out  out  1   1 = write
//  ahb_hsize_out   out  3   000/001/010
//  ahb_hwdata_out  out  32  write data, driven in DATA state
//  ahb_hrdata_in   in   32  read data
//  ahb_hready_in   in   1   slave ready
//  ahb_hresp_in    in   1   1 = ERROR
//  stall_out       out  1   hold pipeline
//  err_out         out  1   pulse with valid/done on bus error, timeout or illegal request
// BEHAVIOUR
//  Reset: state IDLE, last_grant=LOAD, every output 0 (htrans=IDLE), wait counter 0.
//    Reset asserted mid-transfer aborts immediately, no completion pulse.
//  States: IDLE -> ADDR -> DATA -> IDLE.
//   IDLE: samples requests. On a tie, grants the requester not in last_grant, so the first tie after reset goes to the store.
//     Latches addr, hsize, hwrite and wdata, then goes to ADDR.
//     Illegal request: goes to no state. Pulses done/valid+err next cycle; no bus activity.
//       Illegal load: misaligned (half addr[0]=1; word addr[1:0]!=0) or size 11.
//       Illegal store: mask not one of 0001,0010,0100,1000,0011,1100,1111.
//   ADDR: htrans=NONSEQ with haddr/hwrite/hsize stable. On hready=1: gnt pulse, go to DATA, htrans=IDLE.
//   DATA: hwdata held. On hready=1: capture hrdata (reads), go to IDLE.
//     done/valid is a registered pulse in the next cycle.
//     err_out accompanies it if hresp=1 was seen on the completing cycle (two-cycle ERROR response).
//  Store address and size: haddr = {st_addr_in[31:2], lowest set mask bit index}.
//    hsize: single bit -> 000, 0011/1100 -> 001, 1111 -> 010.
//  Load address and size: haddr = ld_addr_in; hsize = {1'b0, ld_size_in}.
//  Timeout: counter cleared on state entry, counts while hready=0 in ADDR/DATA.
//    At TIMEOUT: htrans=IDLE, go to IDLE, pulse done/valid+err.
//  Latency (zero wait states): req cycle 0 -> gnt cycle 1 -> done/valid cycle 3.
//    Minimum 1 IDLE cycle between transfers; each wait state adds 1.
//  Completion cycle: the requester whose done/valid is high has its req ignored that cycle; it drops req next cycle.
//  stall_out = (state!=IDLE) | ((ld_req_in|st_req_in) & ~completing-requester-only).
//  last_grant updates on every grant.
//  One outstanding transfer only; no pipelined address overlap.
// STRUCTURE
//  msrv32_dbus_defines.vh: HTRANS_IDLE/NONSEQ, HSIZE_B/H/W, state encodings, LAST_LD/LAST_ST.
//  Sub-module msrv32_dbus_size_decode: combinational mask/size/addr -> hsize, haddr[1:0], illegal flag.
// TESTING
//  1 Store: mask=1111, addr=0x100, data=0xDEADBEEF, hready=1 -> cycle1 haddr=0x100 NONSEQ hwrite=1 hsize=010;
//    cycle2 hwdata=0xDEADBEEF; cycle3 st_done=1, err=0.
//  2 Load half at 0x202, 2 wait states in DATA, hrdata=0x1234_0000 ->
//    ld_valid 2 cycles later than zero-wait, ld_rdata=0x12340000, haddr=0x202, hsize=001.
//  3 ld_req and st_req rise together twice -> store granted first, then load, then store.
//    stall_out high throughout; 1 IDLE cycle between transfers.
//  4 Store mask=0100, addr=0x40 -> haddr=0x42 hsize=000.
//    Store mask=0101 -> no NONSEQ, st_done+err next cycle.
//  5 Load word, hresp=1 with hready=0 then hresp=1 with hready=1 -> ld_valid+err, ld_rdata=0.
//    hready held 0 for 16 cycles -> htrans=IDLE, err pulse, state IDLE.
//  6 rst_n_in low during DATA -> all outputs 0 immediately, no done.
//    After release, a pending st_req is re-granted from IDLE.

Source files
------------

// File: rtl/msrv32_dbus_arbiter_pkg.sv
// msrv32 data-bus arbiter: shared constants and types.
// AHB encodings, FSM states, grant owners.
package msrv32_dbus_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_B = 3'b000;
  localparam logic [2:0] HSIZE_H = 3'b001;
  localparam logic [2:0] HSIZE_W = 3'b010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic LAST_LD = 1'b0;
  localparam logic LAST_ST = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
  } xfer_t;

endpackage

// File: rtl/msrv32_dbus_arbiter_if.sv
// msrv32 data-bus arbiter: load/store/AHB bundle.
// master = arbiter side, slave = LSU + AHB side.
interface msrv32_dbus_arbiter_if;

  logic        ld_req_in;
  logic [31:0] ld_addr_in;
  logic [1:0]  ld_size_in;
  logic        ld_gnt_out;
  logic        ld_valid_out;
  logic [31:0] ld_rdata_out;

  logic        st_req_in;
  logic [31:0] st_addr_in;
  logic [31:0] st_wdata_in;
  logic [3:0]  st_mask_in;
  logic        st_gnt_out;
  logic        st_done_out;

  logic [31:0] ahb_haddr_out;
  logic [1:0]  ahb_htrans_out;
  logic        ahb_hwrite_out;
  logic [2:0]  ahb_hsize_out;
  logic [31:0] ahb_hwdata_out;
  logic [31:0] ahb_hrdata_in;
  logic        ahb_hready_in;
  logic        ahb_hresp_in;

  logic        stall_out;
  logic        err_out;

  modport master (
    input  ld_req_in, ld_addr_in, ld_size_in,
    output ld_gnt_out, ld_valid_out, ld_rdata_out,
    input  st_req_in, st_addr_in, st_wdata_in,
    input  st_mask_in,
    output st_gnt_out, st_done_out,
    output ahb_haddr_out, ahb_htrans_out,
    output ahb_hwrite_out, ahb_hsize_out,
    output ahb_hwdata_out,
    input  ahb_hrdata_in, ahb_hready_in,
    input  ahb_hresp_in,
    output stall_out, err_out
  );

  modport slave (
    output ld_req_in, ld_addr_in, ld_size_in,
    input  ld_gnt_out, ld_valid_out, ld_rdata_out,
    output st_req_in, st_addr_in, st_wdata_in,
    output st_mask_in,
    input  st_gnt_out, st_done_out,
    input  ahb_haddr_out, ahb_htrans_out,
    input  ahb_hwrite_out, ahb_hsize_out,
    input  ahb_hwdata_out,
    output ahb_hrdata_in, ahb_hready_in,
    output ahb_hresp_in,
    input  stall_out, err_out
  );

endinterface

// File: rtl/msrv32_dbus_size_decode.sv
// msrv32 data-bus arbiter: mask/size decode.
// Store mask -> hsize, haddr[1:0]; legality checks.
module msrv32_dbus_size_decode
  import msrv32_dbus_arbiter_pkg::*;
(
  input  logic [3:0] st_mask_in,
  input  logic [1:0] ld_alo_in,
  input  logic [1:0] ld_size_in,
  output logic [2:0] st_hsize_out,
  output logic [1:0] st_alo_out,
  output logic       st_bad_out,
  output logic       ld_bad_out
);

  always_comb begin
    st_hsize_out = HSIZE_B;
    st_alo_out   = 2'd0;
    st_bad_out   = 1'b0;
    unique case (1'b1)
      st_mask_in == 4'b0001: st_alo_out = 2'd0;
      st_mask_in == 4'b0010: st_alo_out = 2'd1;
      st_mask_in == 4'b0100: st_alo_out = 2'd2;
      st_mask_in == 4'b1000: st_alo_out = 2'd3;
      st_mask_in == 4'b0011: st_hsize_out = HSIZE_H;
      st_mask_in == 4'b1100: begin
        st_hsize_out = HSIZE_H;
        st_alo_out   = 2'd2;
      end
      st_mask_in == 4'b1111: st_hsize_out = HSIZE_W;
      default: st_bad_out = 1'b1;
    endcase
  end

  always_comb begin
    unique case (ld_size_in)
      2'b00:   ld_bad_out = 1'b0;
      2'b01:   ld_bad_out = ld_alo_in[0];
      2'b10:   ld_bad_out = |ld_alo_in;
      default: ld_bad_out = 1'b1;
    endcase
  end

endmodule

// File: rtl/msrv32_dbus_arbiter.sv
// msrv32 data-bus arbiter: load/store -> AHB-Lite.
// One transfer at a time, round-robin on ties.
module msrv32_dbus_arbiter
  import msrv32_dbus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  msrv32_dbus_arbiter_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          own_q, own_d;
  xfer_t         xfer_q, xfer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_vld_q, ld_vld_d;
  logic          st_done_q, st_done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [2:0] st_hsize;
  logic [1:0] st_alo;
  logic       st_bad, ld_bad;
  logic       ld_eff, st_eff;
  logic       pick_ld, pick_st;
  logic       in_addr, in_data, busy;
  logic       hready, expire;
  logic       fin, fin_err;
  logic       unused_st_alo;

  msrv32_dbus_size_decode u_dec (
    .st_mask_in   (bus.st_mask_in),
    .ld_alo_in    (bus.ld_addr_in[1:0]),
    .ld_size_in   (bus.ld_size_in),
    .st_hsize_out (st_hsize),
    .st_alo_out   (st_alo),
    .st_bad_out   (st_bad),
    .ld_bad_out   (ld_bad)
  );

  assign unused_st_alo = ^bus.st_addr_in[1:0];

  assign hready  = bus.ahb_hready_in;
  assign in_addr = state_q == S_ADDR;
  assign in_data = state_q == S_DATA;
  assign busy    = in_addr | in_data;
  assign expire  = ~hready & (cnt_q == TO_LAST);

  assign ld_eff  = bus.ld_req_in & ~ld_vld_q;
  assign st_eff  = bus.st_req_in & ~st_done_q;
  assign pick_st = st_eff &
                   (~ld_eff | (last_q == LAST_LD));
  assign pick_ld = ld_eff & ~pick_st;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    own_d     = own_q;
    xfer_d    = xfer_q;
    ld_vld_d  = 1'b0;
    st_done_d = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_st) begin
          if (st_bad) begin
            st_done_d = 1'b1;
            err_d     = 1'b1;
          end else begin
            state_d      = S_ADDR;
            own_d        = LAST_ST;
            last_d       = LAST_ST;
            xfer_d.addr  = {bus.st_addr_in[31:2],
                            st_alo};
            xfer_d.size  = st_hsize;
            xfer_d.write = 1'b1;
            xfer_d.wdata = bus.st_wdata_in;
          end
        end else if (pick_ld) begin
          if (ld_bad) begin
            ld_vld_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end else begin
            state_d      = S_ADDR;
            own_d        = LAST_LD;
            last_d       = LAST_LD;
            xfer_d.addr  = bus.ld_addr_in;
            xfer_d.size  = {1'b0, bus.ld_size_in};
            xfer_d.write = 1'b0;
            xfer_d.wdata = '0;
          end
        end
      end
      S_ADDR: begin
        if (hready) begin
          state_d = S_DATA;
        end else if (expire) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      S_DATA: begin
        if (hready) begin
          fin     = 1'b1;
          fin_err = bus.ahb_hresp_in;
        end else if (expire) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = S_IDLE;
      err_d   = fin_err;
      if (own_q == LAST_ST) begin
        st_done_d = 1'b1;
      end else begin
        ld_vld_d = 1'b1;
        rdata_d  = fin_err ? '0 : bus.ahb_hrdata_in;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (busy && !hready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      last_q    <= LAST_LD;
      own_q     <= LAST_LD;
      xfer_q    <= '0;
      cnt_q     <= '0;
      ld_vld_q  <= 1'b0;
      st_done_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      own_q     <= own_d;
      xfer_q    <= xfer_d;
      cnt_q     <= cnt_d;
      ld_vld_q  <= ld_vld_d;
      st_done_q <= st_done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.ahb_htrans_out =
    in_addr ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.ahb_haddr_out  =
    in_addr ? xfer_q.addr : '0;
  assign bus.ahb_hwrite_out =
    in_addr & xfer_q.write;
  assign bus.ahb_hsize_out  =
    in_addr ? xfer_q.size : '0;
  assign bus.ahb_hwdata_out =
    in_data ? xfer_q.wdata : '0;

  assign bus.ld_gnt_out =
    in_addr & hready & (own_q == LAST_LD);
  assign bus.st_gnt_out =
    in_addr & hready & (own_q == LAST_ST);

  assign bus.ld_valid_out = ld_vld_q;
  assign bus.ld_rdata_out = rdata_q;
  assign bus.st_done_out  = st_done_q;
  assign bus.err_out      = err_q;

  assign bus.stall_out =
    rst_n_in & (busy | ld_eff | st_eff);

endmodule

// File: tb/tb_msrv32_dbus_arbiter.sv
// msrv32 data-bus arbiter bench.
// Directed vectors, queued expectations, monitors.
module tb_msrv32_dbus_arbiter;

  typedef struct {
    bit          st;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } cmp_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } ax_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_bad;

  cmp_t exp_q[$];
  ax_t  ax_q[$];
  cmp_t e;
  ax_t  a;
  bit          wd_pend;
  logic [31:0] wd_exp;

  int          cfg_aw;
  int          cfg_dw;
  bit          cfg_err;
  logic [31:0] cfg_rdata;
  int          aw;
  int          dw;
  bit          dph;

  msrv32_dbus_arbiter_if bus ();

  msrv32_dbus_arbiter #(.TIMEOUT(16)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               nm, act, want, cyc);
    end
  endfunction

  task automatic exp_done(
    input bit          st,
    input bit          err,
    input logic [31:0] rd,
    input int          c
  );
    cmp_t x;
    x.st = st; x.err = err; x.rdata = rd; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic exp_ax(
    input logic [31:0] ad,
    input bit          wr,
    input logic [2:0]  sz,
    input logic [31:0] wd
  );
    ax_t x;
    x.addr = ad; x.wr = wr; x.size = sz; x.wdata = wd;
    ax_q.push_back(x);
  endtask

  // AHB slave model
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      aw = 0; dw = 0; dph = 0;
      bus.ahb_hready_in = 1'b1;
      bus.ahb_hresp_in  = 1'b0;
    end else if (bus.ahb_htrans_out == 2'b10) begin
      bus.ahb_hresp_in = 1'b0;
      if (aw < cfg_aw) begin
        bus.ahb_hready_in = 1'b0;
        aw++;
      end else begin
        bus.ahb_hready_in = 1'b1;
        aw = 0;
        dph = 1;
      end
    end else if (dph) begin
      bus.ahb_hresp_in = cfg_err;
      if (dw < cfg_dw) begin
        bus.ahb_hready_in = 1'b0;
        dw++;
      end else begin
        bus.ahb_hready_in = 1'b1;
        bus.ahb_hrdata_in = cfg_rdata;
        dw = 0;
        dph = 0;
      end
    end else begin
      bus.ahb_hready_in = 1'b1;
      bus.ahb_hresp_in  = 1'b0;
      aw = 0;
    end
  end

  // completion scoreboard
  always @(negedge clk) begin
    if (rst_n &&
        (bus.ld_valid_out || bus.st_done_out)) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done: got ld=%0b st=%0b want none (cyc %0d)",
                 bus.ld_valid_out, bus.st_done_out, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_is_store", 32'(bus.st_done_out),
            32'(e.st));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_err", 32'(bus.err_out), 32'(e.err));
        if (!e.st) chk("ld_rdata", bus.ld_rdata_out,
                       e.rdata);
      end
    end else if (bus.err_out) begin
      n_vec++; n_bad++;
      $display("FAIL lone_err: got err=1 want 0 (cyc %0d)",
               cyc);
    end
  end

  // AHB address/data phase monitor
  always @(negedge clk) begin
    if (wd_pend) begin
      chk("hwdata", bus.ahb_hwdata_out, wd_exp);
      wd_pend = 0;
    end
    if (rst_n && bus.ahb_htrans_out == 2'b10 &&
        bus.ahb_hready_in) begin
      if (ax_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_nonseq: got haddr=%h want no transfer",
                 bus.ahb_haddr_out);
      end else begin
        a = ax_q.pop_front();
        chk("haddr", bus.ahb_haddr_out, a.addr);
        chk("hwrite", 32'(bus.ahb_hwrite_out),
            32'(a.wr));
        chk("hsize", 32'(bus.ahb_hsize_out),
            32'(a.size));
        chk("gnt", {30'd0, bus.st_gnt_out,
                    bus.ld_gnt_out},
            a.wr ? 32'd2 : 32'd1);
        if (a.wr) begin
          wd_pend = 1;
          wd_exp  = a.wdata;
        end
      end
    end
  end

  task automatic go_ld(
    input logic [31:0] ad,
    input logic [1:0]  sz
  );
    bus.ld_addr_in = ad;
    bus.ld_size_in = sz;
    bus.ld_req_in  = 1'b1;
  endtask

  task automatic go_st(
    input logic [31:0] ad,
    input logic [31:0] wd,
    input logic [3:0]  mk
  );
    bus.st_addr_in  = ad;
    bus.st_wdata_in = wd;
    bus.st_mask_in  = mk;
    bus.st_req_in   = 1'b1;
  endtask

  task automatic run(input int max, input int stall_n);
    int i;
    bit dl, ds;
    i = 0;
    while ((bus.ld_req_in || bus.st_req_in) &&
           i <= max) begin
      @(negedge clk);
      if (i < stall_n)
        chk("stall_hi", 32'(bus.stall_out), 32'd1);
      else if (i == stall_n)
        chk("stall_lo", 32'(bus.stall_out), 32'd0);
      dl = bus.ld_valid_out;
      ds = bus.st_done_out;
      @(posedge clk); #1;
      if (dl) bus.ld_req_in = 1'b0;
      if (ds) bus.st_req_in = 1'b0;
      i++;
    end
    if (bus.ld_req_in || bus.st_req_in) begin
      n_vec++; n_bad++;
      $display("FAIL run_timeout: got req pending after %0d cycles want completion",
               max);
      bus.ld_req_in = 1'b0;
      bus.st_req_in = 1'b0;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_htrans"}, 32'(bus.ahb_htrans_out), 0);
    chk({nm, "_haddr"}, bus.ahb_haddr_out, 0);
    chk({nm, "_hwdata"}, bus.ahb_hwdata_out, 0);
    chk({nm, "_stall"}, 32'(bus.stall_out), 0);
    chk({nm, "_pulses"},
        {27'd0, bus.ld_gnt_out, bus.st_gnt_out,
         bus.ld_valid_out, bus.st_done_out,
         bus.err_out}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end want finish");
    $fatal(1);
  end

  initial begin
    int t0;
    n_vec = 0; n_bad = 0;
    wd_pend = 0;
    cfg_aw = 0; cfg_dw = 0; cfg_err = 0;
    cfg_rdata = 32'h0;
    rst_n = 1'b0;
    bus.ld_req_in = 1'b0;
    bus.ld_addr_in = '0;
    bus.ld_size_in = '0;
    bus.st_req_in = 1'b0;
    bus.st_addr_in = '0;
    bus.st_wdata_in = '0;
    bus.st_mask_in = '0;
    bus.ahb_hrdata_in = '0;
    bus.ahb_hready_in = 1'b1;
    bus.ahb_hresp_in = 1'b0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // store word, zero wait
    t0 = cyc;
    exp_ax(32'h100, 1, 3'b010, 32'hDEADBEEF);
    exp_done(1, 0, 0, t0 + 3);
    go_st(32'h100, 32'hDEADBEEF, 4'b1111);
    run(20, 3);

    // load half, two data wait states
    cfg_dw = 2;
    cfg_rdata = 32'h1234_0000;
    t0 = cyc;
    exp_ax(32'h202, 0, 3'b001, 0);
    exp_done(0, 0, 32'h1234_0000, t0 + 5);
    go_ld(32'h202, 2'b01);
    run(20, 5);
    cfg_dw = 0;

    // tie: store first, then load
    cfg_rdata = 32'hCAFE_0001;
    t0 = cyc;
    exp_ax(32'h300, 1, 3'b010, 32'h1111_1111);
    exp_ax(32'h400, 0, 3'b010, 0);
    exp_done(1, 0, 0, t0 + 3);
    exp_done(0, 0, 32'hCAFE_0001, t0 + 6);
    go_st(32'h300, 32'h1111_1111, 4'b1111);
    go_ld(32'h400, 2'b10);
    run(30, 6);

    // second tie: last grant was load -> store
    cfg_rdata = 32'h5500_0000;
    t0 = cyc;
    exp_ax(32'h500, 1, 3'b001, 32'h0000_BEEF);
    exp_ax(32'h603, 0, 3'b000, 0);
    exp_done(1, 0, 0, t0 + 3);
    exp_done(0, 0, 32'h5500_0000, t0 + 6);
    go_st(32'h500, 32'h0000_BEEF, 4'b0011);
    go_ld(32'h603, 2'b00);
    run(30, 6);

    // single-lane store address
    t0 = cyc;
    exp_ax(32'h42, 1, 3'b000, 32'h00AB_0000);
    exp_done(1, 0, 0, t0 + 3);
    go_st(32'h40, 32'h00AB_0000, 4'b0100);
    run(20, 3);

    // illegal store mask
    t0 = cyc;
    exp_done(1, 1, 0, t0 + 1);
    go_st(32'h44, 32'h1234_5678, 4'b0101);
    run(10, 1);

    // misaligned half load
    t0 = cyc;
    exp_done(0, 1, 0, t0 + 1);
    go_ld(32'h201, 2'b01);
    run(10, 1);

    // two-cycle ERROR response
    cfg_dw = 1;
    cfg_err = 1;
    cfg_rdata = 32'h9999_9999;
    t0 = cyc;
    exp_ax(32'h800, 0, 3'b010, 0);
    exp_done(0, 1, 0, t0 + 4);
    go_ld(32'h800, 2'b10);
    run(20, 4);
    cfg_dw = 0;
    cfg_err = 0;

    // hready stuck low in ADDR
    cfg_aw = 1000;
    t0 = cyc;
    exp_done(0, 1, 0, t0 + 17);
    go_ld(32'h900, 2'b10);
    run(40, 17);
    @(negedge clk);
    chk("to_htrans", 32'(bus.ahb_htrans_out), 0);
    chk("to_stall", 32'(bus.stall_out), 0);
    @(posedge clk); #1;
    cfg_aw = 0;

    // reset during DATA, then re-grant
    cfg_dw = 5;
    t0 = cyc;
    exp_ax(32'hA00, 1, 3'b010, 32'h0BAD_F00D);
    go_st(32'hA00, 32'h0BAD_F00D, 4'b1111);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(bus.st_done_out), 0);
    @(posedge clk); #1;
    cfg_dw = 0;
    rst_n = 1'b1;
    t0 = cyc;
    exp_ax(32'hA00, 1, 3'b010, 32'h0BAD_F00D);
    exp_done(1, 0, 0, t0 + 3);
    run(20, 3);

    repeat (3) @(posedge clk);
    chk("exp_q_left", 32'(exp_q.size()), 0);
    chk("ax_q_left", 32'(ax_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
